icache: RTL



---
 rtl/icache.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetch port and program memory.
// Hits answer in the cycle after the request; misses refill the whole line in one burst.
module icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr_i,
  output logic                  cpu_req_ready_o,
  output logic                  cpu_resp_valid_o,
  output logic [DATA_WIDTH-1:0] cpu_resp_instr_o,
  input  logic                  flush_i,
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_data_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int TAG_W = WA_W - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP
  } state_t;

  state_t                r_state;
  logic [WA_W-1:0]       r_addr;
  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES][LINE_WORDS];
  logic [OFF_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_flushed;

  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_unused;

  // Byte-within-word bits never matter for 32-bit instruction fetch.
  assign w_unused = ^cpu_req_addr_i[1:0];

  assign w_off    = r_addr[OFF_W-1:0];
  assign w_idx    = r_addr[OFF_W +: IDX_W];
  assign w_tag    = r_addr[WA_W-1 -: TAG_W];
  assign w_hit    = (r_state == LOOKUP) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept = cpu_req_valid_i && cpu_req_ready_o;
  assign w_beat   = (r_state == REFILL) && mem_resp_valid_i;
  assign w_last   = w_beat && (r_cnt == LAST_BEAT);

  always_comb begin
    cpu_req_ready_o  = 1'b0;
    cpu_resp_valid_o = 1'b0;
    cpu_resp_instr_o = '0;
    mem_req_valid_o  = 1'b0;
    mem_req_addr_o   = '0;
    case (r_state)
      IDLE: cpu_req_ready_o = 1'b1;
      LOOKUP: begin
        if (w_hit) begin
          cpu_req_ready_o  = 1'b1;
          cpu_resp_valid_o = 1'b1;
          cpu_resp_instr_o = r_data[w_idx][w_off];
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {w_tag, w_idx, {(OFF_W + 2){1'b0}}};
      end
      RESP: begin
        cpu_resp_valid_o = 1'b1;
        cpu_resp_instr_o = r_buf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_valid   <= '0;
      r_cnt     <= '0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= cpu_req_addr_i[ADDR_WIDTH-1:2];
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (cpu_req_valid_i) r_addr <= cpu_req_addr_i[ADDR_WIDTH-1:2];
            else                 r_state <= IDLE;
          end else begin
            r_flushed <= 1'b0;
            r_state   <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready_i) begin
            r_cnt   <= '0;
            r_state <= REFILL;
          end
        end
        REFILL: begin
          if (w_beat) r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_valid[w_idx] <= ~(r_flushed | flush_i);
            r_state        <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // A flush overrides any valid bit set on the same edge.
      if (flush_i) begin
        r_valid <= '0;
        if ((r_state == MISS_REQ) || (r_state == REFILL)) r_flushed <= 1'b1;
      end
    end
  end

  // Line storage and the response buffer carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[w_idx][r_cnt] <= mem_resp_data_i;
      if (r_cnt == w_off) r_buf <= mem_resp_data_i;
      if (w_last) r_tag[w_idx] <= w_tag;
    end
  end

endmodule
